// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants and small shared helpers for the VGA scan timer.
package vga_timing_pkg;

  localparam int WIDTH   = 640;
  localparam int HEIGHT  = 480;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b0;

  localparam int X_W  = 10;
  localparam int Y_W  = 9;
  localparam int FC_W = 8;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic screen_end;
    logic line_start;
  } vga_flags_t;

  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  function automatic vga_flags_t flags_reset(input logic pol);
    vga_flags_t f;
    f       = '0;
    f.hsync = ~pol;
    f.vsync = ~pol;
    return f;
  endfunction

endpackage

// File: rtl/vga_scan_timer_if.sv
// Timing bundle between the scan timer (master) and the VGA controller (slave).
interface vga_scan_timer_if;
  import vga_timing_pkg::*;

  logic            en;
  logic            hSync;
  logic            vSync;
  logic            active;
  logic            screenEnd;
  logic            lineStart;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic [FC_W-1:0] frameCount;

  modport master (
    input  en,
    output hSync, vSync, active, screenEnd, lineStart, x, y, frameCount
  );

  modport slave (
    output en,
    input  hSync, vSync, active, screenEnd, lineStart, x, y, frameCount
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis; o_wrap marks the last position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int  TOTAL = 800,
  localparam int W     = cnt_width(TOTAL)
) (
  input  logic         clk25,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] r_cnt;

  assign o_wrap = (r_cnt == LAST);
  assign o_cnt  = r_cnt;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_scan_timer.sv
// 640x480@60 raster timing source: registered sync, visibility, position and frame pulses.
module vga_scan_timer #(
  parameter int   WIDTH    = vga_timing_pkg::WIDTH,
  parameter int   HEIGHT   = vga_timing_pkg::HEIGHT,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic                  clk25,
  input  logic                  reset,
  vga_scan_timer_if.master      vif
);

  localparam int H_TOT = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int HC_W  = vga_timing_pkg::cnt_width(H_TOT);
  localparam int VC_W  = vga_timing_pkg::cnt_width(V_TOT);
  localparam int X_W   = vga_timing_pkg::X_W;
  localparam int Y_W   = vga_timing_pkg::Y_W;
  localparam int FC_W  = vga_timing_pkg::FC_W;

  localparam logic [HC_W-1:0] H_VIS_END  = HC_W'(WIDTH);
  localparam logic [HC_W-1:0] HS_FIRST   = HC_W'(WIDTH + H_FP);
  localparam logic [HC_W-1:0] HS_LAST    = HC_W'(WIDTH + H_FP + H_SYNC - 1);
  localparam logic [VC_W-1:0] V_VIS_END  = VC_W'(HEIGHT);
  localparam logic [VC_W-1:0] VS_FIRST   = VC_W'(HEIGHT + V_FP);
  localparam logic [VC_W-1:0] VS_LAST    = VC_W'(HEIGHT + V_FP + V_SYNC - 1);

  logic [HC_W-1:0] w_h_cnt;
  logic [VC_W-1:0] w_v_cnt;
  logic            w_h_wrap;
  logic            w_v_wrap_unused;
  logic            w_v_en;

  vga_timing_pkg::vga_flags_t w_next;
  logic [X_W-1:0]             w_next_x;
  logic [Y_W-1:0]             w_next_y;

  vga_timing_pkg::vga_flags_t r_flags;
  logic [X_W-1:0]             r_x;
  logic [Y_W-1:0]             r_y;
  logic [FC_W-1:0]            r_frame_count;

  // Rows only advance on the pixel edge that wraps the column counter.
  assign w_v_en = vif.en && w_h_wrap;

  vga_axis_counter #(.TOTAL(H_TOT)) u_h_cnt (
    .clk25  (clk25),
    .reset  (reset),
    .i_en   (vif.en),
    .o_cnt  (w_h_cnt),
    .o_wrap (w_h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOT)) u_v_cnt (
    .clk25  (clk25),
    .reset  (reset),
    .i_en   (w_v_en),
    .o_cnt  (w_v_cnt),
    .o_wrap (w_v_wrap_unused)
  );

  // Decode of the current (pre-increment) counter position, registered below.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    w_next   = '0;
    w_next_x = '0;
    w_next_y = '0;

    w_next.active     = (w_h_cnt < H_VIS_END) && (w_v_cnt < V_VIS_END);
    w_next.hsync      = (w_h_cnt >= HS_FIRST && w_h_cnt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    w_next.vsync      = (w_v_cnt >= VS_FIRST && w_v_cnt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    w_next.line_start = (w_h_cnt == '0);
    w_next.screen_end = (w_h_cnt == '0) && (w_v_cnt == V_VIS_END);

    if (w_h_cnt < H_VIS_END) begin
      w_next_x = X_W'(w_h_cnt);
    end
    if (w_v_cnt < V_VIS_END) begin
      w_next_y = Y_W'(w_v_cnt);
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_flags       <= vga_timing_pkg::flags_reset(SYNC_POL);
      r_x           <= '0;
      r_y           <= '0;
      r_frame_count <= '0;
    end else if (vif.en) begin
      r_flags <= w_next;
      r_x     <= w_next_x;
      r_y     <= w_next_y;
      if (w_next.screen_end) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end else begin
      // Frozen: levels hold, but pulses drop so a stall never repeats them.
      r_flags.line_start <= 1'b0;
      r_flags.screen_end <= 1'b0;
    end
  end

  assign vif.hSync      = r_flags.hsync;
  assign vif.vSync      = r_flags.vsync;
  assign vif.active     = r_flags.active;
  assign vif.screenEnd  = r_flags.screen_end;
  assign vif.lineStart  = r_flags.line_start;
  assign vif.x          = r_x;
  assign vif.y          = r_y;
  assign vif.frameCount = r_frame_count;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Randomised-enable bench for vga_scan_timer on a shrunken raster, checked against a position model.
module tb_vga_scan_timer;

  // Shrunken geometry keeps 256+ frames short; the model is generic in these.
  localparam int  W      = 10;
  localparam int  HFP    = 2;
  localparam int  HSYNC  = 2;
  localparam int  HBP    = 2;
  localparam int  H      = 6;
  localparam int  VFP    = 1;
  localparam int  VSYNC  = 2;
  localparam int  VBP    = 2;
  localparam int  HT     = W + HFP + HSYNC + HBP;
  localparam int  VT     = H + VFP + VSYNC + VBP;
  localparam int  FT     = HT * VT;
  localparam int  SE_POS = H * HT;
  localparam bit  POL    = 1'b0;

  logic clk25 = 1'b0;
  logic reset;

  always #20 clk25 = ~clk25;

  vga_scan_timer_if vif ();

  vga_scan_timer #(
    .WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HSYNC), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSYNC), .V_BP(VBP), .SYNC_POL(POL)
  ) dut (
    .clk25 (clk25),
    .reset (reset),
    .vif   (vif)
  );

  int     n_cmp;
  int     n_bad;
  longint n_edges;   // enabled edges since the last reset
  bit     last_en;   // whether the most recent edge was enabled
  longint se_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint frames_done(input longint k);
    return (k >= SE_POS) ? ((k - SE_POS) / FT + 1) : 0;
  endfunction

  function automatic longint cur_pos();
    return (n_edges == 0) ? -1 : (n_edges - 1) % FT;
  endfunction

  // Packed as {hSync, vSync, active, screenEnd, lineStart, x[9:0], y[8:0], frameCount[7:0]}.
  function automatic logic [31:0] model_out();
    longint     k, p, h, v;
    logic       hs, vs, act, se, ls;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] fc;
    if (n_edges == 0) return {!POL, !POL, 30'b0};
    k   = n_edges - 1;
    p   = k % FT;
    h   = p % HT;
    v   = p / HT;
    act = (h < W) && (v < H);
    x   = (h < W) ? 10'(h) : 10'd0;
    y   = (v < H) ? 9'(v) : 9'd0;
    hs  = (h >= W + HFP && h < W + HFP + HSYNC) ? POL : !POL;
    vs  = (v >= H + VFP && v < H + VFP + VSYNC) ? POL : !POL;
    ls  = last_en && (h == 0);
    se  = last_en && (p == SE_POS);
    fc  = 8'(frames_done(k) % 256);
    return {hs, vs, act, se, ls, x, y, fc};
  endfunction

  function automatic logic [31:0] dut_out();
    return {vif.hSync, vif.vSync, vif.active, vif.screenEnd, vif.lineStart,
            vif.x, vif.y, vif.frameCount};
  endfunction

  task automatic step(input bit e);
    vif.en = e;
    @(posedge clk25);
    if (!reset) begin
      if (e) n_edges++;
      last_en = e;
    end
    @(negedge clk25);
    if (vif.screenEnd) se_seen++;
    check("outputs", dut_out(), model_out());
  endtask

  task automatic advance_to(input longint target, input string tag);
    int guard;
    guard = 0;
    while (cur_pos() != target && guard < 2 * FT) begin
      step(1'b1);
      guard++;
    end
    if (cur_pos() != target) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int     act_cnt, hs_low, hs_first, guard;
    logic [7:0] prev_fc;
    bit     saw_wrap;

    n_cmp   = 0;
    n_bad   = 0;
    n_edges = 0;
    last_en = 1'b0;
    se_seen = 0;
    reset   = 1'b1;
    vif.en  = 1'b1;

    // Reset held for 5 cycles with en high: outputs stay at reset values.
    for (int i = 0; i < 5; i++) step(1'b1);
    check("rst_hsync",  32'(vif.hSync), 32'(!POL));
    check("rst_vsync",  32'(vif.vSync), 32'(!POL));
    check("rst_active", 32'(vif.active), 32'd0);
    check("rst_fc",     32'(vif.frameCount), 32'd0);
    reset = 1'b0;

    // First line: pixel (0,0) on the first edge, then visible/sync widths.
    act_cnt  = 0;
    hs_low   = 0;
    hs_first = -1;
    for (int i = 0; i < HT; i++) begin
      step(1'b1);
      if (i == 0) begin
        check("first_x",      32'(vif.x), 32'd0);
        check("first_y",      32'(vif.y), 32'd0);
        check("first_active", 32'(vif.active), 32'd1);
        check("first_ls",     32'(vif.lineStart), 32'd1);
      end
      if (vif.active) act_cnt++;
      if (vif.hSync == POL) begin
        if (hs_first < 0) hs_first = i;
        hs_low++;
      end
    end
    check("line_active_cycles", 32'(act_cnt), 32'(W));
    check("hsync_low_cycles",   32'(hs_low), 32'(HSYNC));
    check("hsync_start",        32'(hs_first), 32'(W + HFP));
    step(1'b1);
    check("next_line_ls", 32'(vif.lineStart), 32'd1);
    check("next_line_y",  32'(vif.y), 32'd1);

    // Over 256 frames with a randomly stalling enable.
    saw_wrap = 1'b0;
    prev_fc  = vif.frameCount;
    guard    = 0;
    while (n_edges < 257 * FT && n_bad <= 50 && guard < 70000) begin
      step($urandom_range(15) != 0);
      if (prev_fc == 8'd255 && vif.frameCount == 8'd0) saw_wrap = 1'b1;
      prev_fc = vif.frameCount;
      guard++;
    end
    check("screen_end_pulses",   32'(se_seen), 32'(frames_done(n_edges - 1)));
    check("frame_count_wrapped", 32'(saw_wrap), 32'd1);

    // Stall 37 cycles mid-frame: everything freezes, pulses stay low, then resume.
    advance_to(3 * HT + 7, "freeze_reach_timeout");
    for (int i = 0; i < 37; i++) step(1'b0);
    check("freeze_x",  32'(vif.x), 32'd7);
    check("freeze_y",  32'(vif.y), 32'd3);
    check("freeze_ls", 32'(vif.lineStart), 32'd0);
    check("freeze_se", 32'(vif.screenEnd), 32'd0);
    step(1'b1);
    check("resume_x", 32'(vif.x), 32'd8);
    check("resume_y", 32'(vif.y), 32'd3);

    // Reset inside both sync pulses: outputs clear without a clock edge.
    advance_to((H + VFP) * HT + W + HFP, "sync_reach_timeout");
    check("pre_rst_hsync", 32'(vif.hSync), 32'(POL));
    check("pre_rst_vsync", 32'(vif.vSync), 32'(POL));
    #5 reset = 1'b1;
    #1;
    check("async_hsync",  32'(vif.hSync), 32'(!POL));
    check("async_vsync",  32'(vif.vSync), 32'(!POL));
    check("async_active", 32'(vif.active), 32'd0);
    check("async_fc",     32'(vif.frameCount), 32'd0);
    n_edges = 0;
    last_en = 1'b0;
    se_seen = 0;
    step(1'b1);
    step(1'b1);
    reset = 1'b0;
    step(1'b1);
    check("restart_x",  32'(vif.x), 32'd0);
    check("restart_y",  32'(vif.y), 32'd0);
    check("restart_ls", 32'(vif.lineStart), 32'd1);
    for (int i = 0; i < FT + 20; i++) step($urandom_range(7) != 0);
    check("restart_se_pulses", 32'(se_seen), 32'(frames_done(n_edges - 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
